dcache_mshr: RTL and testbench

- Non-blocking data-cache controller directly downstream of the LSQ, and the LSQ's only path to memory.
- Receives LSQ load/store commands and answers load hits combinationally from a direct-mapped quadword cache.
- Forwards misses and write-through stores to the memory bus, tracking outstanding loads in an MSHR table.
- Returns fill data to the LSQ by memory tag, in the same cycle the memory presents it.

---
 rtl/dcache_mshr_pkg.sv | 36 +++
 rtl/dcache_mshr_if.sv | 41 ++++
 rtl/dcache_array.sv | 53 +++++
 rtl/dcache_mshr.sv | 166 ++++++++++++++++
 tb/tb_dcache_mshr.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_mshr_pkg.sv
// Shared types and sizing for the non-blocking data cache and its MSHR table.
package dcache_mshr_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  localparam int DCACHE_LINES = 32;
  localparam int MSHR_SIZE    = 4;
  localparam int IDX_W        = $clog2(DCACHE_LINES);
  localparam int TAG_W        = 64 - 3 - IDX_W;
  localparam int MSHR_W       = $clog2(MSHR_SIZE);
  localparam int MEM_TAG_W    = 4;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } dcache_line_t;

  typedef struct packed {
    logic                 valid;
    logic                 stale;
    logic [MEM_TAG_W-1:0] mem_tag;
    logic [IDX_W-1:0]     addr_index;
    logic [TAG_W-1:0]     addr_tag;
  } mshr_entry_t;

  // Rebuild a quadword-aligned byte address from its upper bits.
  function automatic logic [63:0] quad_addr(input logic [IDX_W+TAG_W-1:0] qw);
    return {qw, 3'b000};
  endfunction

endpackage

// File: rtl/dcache_mshr_if.sv
// LSQ-facing and memory-facing signal bundle of the data cache.
interface dcache_mshr_if;

  dcache_mshr_pkg::BUS_COMMAND lsq2Dcache_command;
  logic [63:0]                 lsq2Dcache_addr;
  logic [63:0]                 lsq2Dcache_data;

  logic                        cache_hit;
  logic [63:0]                 Dcache2lsq_data;
  logic [3:0]                  Dcache2lsq_response;
  logic [3:0]                  Dcache2lsq_tag;
  logic [63:0]                 Dcache2lsq_fill_data;
  logic                        mshr_full;

  dcache_mshr_pkg::BUS_COMMAND proc2mem_command;
  logic [63:0]                 proc2mem_addr;
  logic [63:0]                 proc2mem_data;

  logic [3:0]                  mem2proc_response;
  logic [3:0]                  mem2proc_tag;
  logic [63:0]                 mem2proc_data;

  // The environment (LSQ + memory) drives requests and memory replies.
  modport master (
    output lsq2Dcache_command, lsq2Dcache_addr, lsq2Dcache_data,
    output mem2proc_response, mem2proc_tag, mem2proc_data,
    input  cache_hit, Dcache2lsq_data, Dcache2lsq_response, Dcache2lsq_tag,
    input  Dcache2lsq_fill_data, mshr_full,
    input  proc2mem_command, proc2mem_addr, proc2mem_data
  );

  // The cache controller consumes requests and replies, drives everything else.
  modport slave (
    input  lsq2Dcache_command, lsq2Dcache_addr, lsq2Dcache_data,
    input  mem2proc_response, mem2proc_tag, mem2proc_data,
    output cache_hit, Dcache2lsq_data, Dcache2lsq_response, Dcache2lsq_tag,
    output Dcache2lsq_fill_data, mshr_full,
    output proc2mem_command, proc2mem_addr, proc2mem_data
  );

endinterface

// File: rtl/dcache_array.sv
// Direct-mapped quadword tag/data/valid store: one combinational read port,
// two write ports where a store hit beats a fill to the same line.
module dcache_array
  import dcache_mshr_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index,
  output dcache_line_t     rd_line,
  input  logic             st_en,
  input  logic [IDX_W-1:0] st_index,
  input  logic [63:0]      st_data,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [63:0]      fill_data
);

  logic             line_valid [DCACHE_LINES];
  logic [TAG_W-1:0] line_tag   [DCACHE_LINES];
  logic [63:0]      line_data  [DCACHE_LINES];
  logic             fill_win;

  // A store hit to the fill's line suppresses the whole fill write, so the
  // line keeps its (matching) tag and takes the newer store data.
  assign fill_win = fill_en && !(st_en && (st_index == fill_index));

  // Combinational lookup of the addressed line.
  always_comb begin
    rd_line.valid = line_valid[rd_index];
    rd_line.tag   = line_tag[rd_index];
    rd_line.data  = line_data[rd_index];
  end

  // Valid bits: cleared by reset, set by a winning fill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DCACHE_LINES; i++) line_valid[i] <= 1'b0;
    end else if (fill_win) begin
      line_valid[fill_index] <= 1'b1;
    end
  end

  // Tag and data payload; meaningless while the valid bit is clear.
  always_ff @(posedge clock) begin
    if (fill_win) begin
      line_tag[fill_index]  <= fill_tag;
      line_data[fill_index] <= fill_data;
    end
    if (st_en) line_data[st_index] <= st_data;
  end

endmodule

// File: rtl/dcache_mshr.sv
// Non-blocking data cache between the LSQ and memory: combinational load-hit
// path, write-through stores, and an MSHR table tracking outstanding misses.
module dcache_mshr
  import dcache_mshr_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  dcache_mshr_if.slave  bus
);

  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;
  logic             addr_lsb_unused;
  logic             is_load;
  logic             is_store;
  logic             line_match;
  logic             load_hit;
  logic             mem_accept;

  mshr_entry_t      mshr_q [MSHR_SIZE];
  mshr_entry_t      mshr_d [MSHR_SIZE];
  logic             all_valid;
  logic             free_found;
  logic [MSHR_W-1:0] free_idx;
  logic             fill_found;
  logic [MSHR_W-1:0] fill_idx;

  logic             alloc;
  logic             store_accept;
  logic             store_write;
  logic             store_hits_fill;
  logic             fill_write;
  dcache_line_t     rd_line;

  assign req_index       = bus.lsq2Dcache_addr[IDX_W+2:3];
  assign req_tag         = bus.lsq2Dcache_addr[63:IDX_W+3];
  assign addr_lsb_unused = ^bus.lsq2Dcache_addr[2:0];

  assign is_load    = (bus.lsq2Dcache_command == BUS_LOAD);
  assign is_store   = (bus.lsq2Dcache_command == BUS_STORE);
  assign line_match = rd_line.valid && (rd_line.tag == req_tag);
  assign load_hit   = is_load && line_match;
  assign mem_accept = (bus.mem2proc_response != '0);

  dcache_array u_array (
    .clock      (clock),
    .reset      (reset),
    .rd_index   (req_index),
    .rd_line    (rd_line),
    .st_en      (store_write),
    .st_index   (req_index),
    .st_data    (bus.lsq2Dcache_data),
    .fill_en    (fill_write),
    .fill_index (mshr_q[fill_idx].addr_index),
    .fill_tag   (mshr_q[fill_idx].addr_tag),
    .fill_data  (bus.mem2proc_data)
  );

  // Occupancy: lowest free slot and the all-valid flag, from registered state
  // only, so a slot freed by this cycle's fill is not reused until next cycle.
  always_comb begin
    all_valid  = 1'b1;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < MSHR_SIZE; i++) begin
      if (!mshr_q[i].valid) begin
        all_valid = 1'b0;
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = MSHR_W'(i);
        end
      end
    end
  end

  // Match the completing memory tag against outstanding misses.
  always_comb begin
    fill_found = 1'b0;
    fill_idx   = '0;
    if (bus.mem2proc_tag != '0) begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        if (!fill_found && mshr_q[i].valid && (mshr_q[i].mem_tag == bus.mem2proc_tag)) begin
          fill_found = 1'b1;
          fill_idx   = MSHR_W'(i);
        end
      end
    end
  end

  // Write decisions. A store accepted in the same cycle as a fill of the same
  // block makes that fill stale too, otherwise the line would get the old data.
  always_comb begin
    alloc           = is_load && !line_match && free_found && mem_accept;
    store_accept    = is_store && mem_accept;
    store_write     = store_accept && line_match;
    store_hits_fill = store_accept
                      && (mshr_q[fill_idx].addr_index == req_index)
                      && (mshr_q[fill_idx].addr_tag == req_tag);
    fill_write      = fill_found && !mshr_q[fill_idx].stale && !store_hits_fill;
  end

  // LSQ- and memory-facing outputs, all combinational.
  always_comb begin
    bus.cache_hit            = 1'b0;
    bus.Dcache2lsq_data      = '0;
    bus.Dcache2lsq_response  = '0;
    bus.Dcache2lsq_tag       = '0;
    bus.Dcache2lsq_fill_data = '0;
    bus.mshr_full            = all_valid;
    bus.proc2mem_command     = BUS_NONE;
    bus.proc2mem_addr        = '0;
    bus.proc2mem_data        = '0;
    if (load_hit) begin
      bus.cache_hit       = 1'b1;
      bus.Dcache2lsq_data = rd_line.data;
    end else if (is_load && !all_valid) begin
      bus.proc2mem_command    = BUS_LOAD;
      bus.proc2mem_addr       = quad_addr(bus.lsq2Dcache_addr[63:3]);
      bus.Dcache2lsq_response = bus.mem2proc_response;
    end else if (is_store) begin
      bus.proc2mem_command    = BUS_STORE;
      bus.proc2mem_addr       = quad_addr(bus.lsq2Dcache_addr[63:3]);
      bus.proc2mem_data       = bus.lsq2Dcache_data;
      bus.Dcache2lsq_response = bus.mem2proc_response;
    end
    if (fill_found) begin
      bus.Dcache2lsq_tag       = bus.mem2proc_tag;
      bus.Dcache2lsq_fill_data = bus.mem2proc_data;
    end
  end

  // Next MSHR table: mark stale on accepted stores, free on fill, allocate on
  // accepted miss.
  always_comb begin
    mshr_d = mshr_q;
    if (store_accept) begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        if (mshr_q[i].valid && (mshr_q[i].addr_index == req_index)
            && (mshr_q[i].addr_tag == req_tag)) begin
          mshr_d[i].stale = 1'b1;
        end
      end
    end
    if (fill_found) begin
      mshr_d[fill_idx].valid = 1'b0;
      mshr_d[fill_idx].stale = 1'b0;
    end
    if (alloc) begin
      mshr_d[free_idx].valid      = 1'b1;
      mshr_d[free_idx].stale      = 1'b0;
      mshr_d[free_idx].mem_tag    = bus.mem2proc_response;
      mshr_d[free_idx].addr_index = req_index;
      mshr_d[free_idx].addr_tag   = req_tag;
    end
  end

  // MSHR table register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSHR_SIZE; i++) mshr_q[i] <= '0;
    end else begin
      for (int i = 0; i < MSHR_SIZE; i++) mshr_q[i] <= mshr_d[i];
    end
  end

endmodule

// File: tb/tb_dcache_mshr.sv
// Bench for dcache_mshr: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the cache and outstanding misses.
module tb_dcache_mshr;
  import dcache_mshr_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dcache_mshr_if bus();
  dcache_mshr dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0]  mt;
    logic [60:0] qa;
    bit          stale;
  } miss_t;

  miss_t       q[$];
  bit          mv  [32];
  logic [55:0] mtg [32];
  logic [63:0] md  [32];

  int n_checks = 0;
  int n_pass   = 0;

  BUS_COMMAND  c_cmd;
  logic [63:0] c_addr, c_data, c_mdata;
  logic [3:0]  c_resp, c_mtag;

  logic        e_hit, e_full;
  logic [63:0] e_ldata, e_fdata, e_paddr, e_pdata;
  logic [3:0]  e_resp, e_tag;
  BUS_COMMAND  e_cmd;

  logic        a_hit, a_full;
  logic [63:0] a_ldata, a_fdata, a_paddr, a_pdata;
  logic [3:0]  a_resp, a_tag;
  BUS_COMMAND  a_cmd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int find_tag(input logic [3:0] t);
    if (t == 4'd0) return -1;
    foreach (q[i]) if (q[i].mt == t) return i;
    return -1;
  endfunction

  // What the outputs must be for the current inputs and model state.
  task automatic model_outputs();
    logic [4:0]  idx;
    logic [55:0] tg;
    bit full;
    int f;
    idx  = c_addr[7:3];
    tg   = c_addr[63:8];
    full = (q.size() == 4);
    e_hit = 0; e_ldata = 0; e_resp = 0; e_tag = 0; e_fdata = 0;
    e_cmd = BUS_NONE; e_paddr = 0; e_pdata = 0; e_full = full;
    if (c_cmd == BUS_LOAD) begin
      if (mv[idx] && mtg[idx] == tg) begin
        e_hit = 1; e_ldata = md[idx];
      end else if (!full) begin
        e_cmd = BUS_LOAD; e_paddr = {c_addr[63:3], 3'b000}; e_resp = c_resp;
      end
    end else if (c_cmd == BUS_STORE) begin
      e_cmd = BUS_STORE; e_paddr = {c_addr[63:3], 3'b000};
      e_pdata = c_data; e_resp = c_resp;
    end
    f = find_tag(c_mtag);
    if (f >= 0) begin
      e_tag = c_mtag; e_fdata = c_mdata;
    end
  endtask

  // State change at the clock edge.
  task automatic model_commit();
    logic [4:0]  idx, fi;
    logic [55:0] tg;
    logic [60:0] qa;
    bit full, hit, store_hit, alloc;
    int f;
    idx  = c_addr[7:3];
    tg   = c_addr[63:8];
    qa   = c_addr[63:3];
    full = (q.size() == 4);
    hit  = mv[idx] && mtg[idx] == tg;
    store_hit = (c_cmd == BUS_STORE) && c_resp != 0 && hit;
    alloc = (c_cmd == BUS_LOAD) && !hit && !full && c_resp != 0;
    if (c_cmd == BUS_STORE && c_resp != 0)
      foreach (q[i]) if (q[i].qa == qa) q[i].stale = 1;
    f = find_tag(c_mtag);
    if (f >= 0) begin
      fi = q[f].qa[4:0];
      if (!q[f].stale && !(store_hit && fi == idx)) begin
        mv[fi] = 1; mtg[fi] = q[f].qa[60:5]; md[fi] = c_mdata;
      end
      q.delete(f);
    end
    if (store_hit) md[idx] = c_data;
    if (alloc) q.push_back('{mt: c_resp, qa: qa, stale: 1'b0});
  endtask

  task automatic sample_and_compare();
    a_hit = bus.cache_hit;          a_ldata = bus.Dcache2lsq_data;
    a_resp = bus.Dcache2lsq_response; a_tag = bus.Dcache2lsq_tag;
    a_fdata = bus.Dcache2lsq_fill_data; a_full = bus.mshr_full;
    a_cmd = bus.proc2mem_command;   a_paddr = bus.proc2mem_addr;
    a_pdata = bus.proc2mem_data;
    chk("cache_hit", a_hit, e_hit);
    chk("Dcache2lsq_data", a_ldata, e_ldata);
    chk("Dcache2lsq_response", a_resp, e_resp);
    chk("Dcache2lsq_tag", a_tag, e_tag);
    chk("Dcache2lsq_fill_data", a_fdata, e_fdata);
    chk("mshr_full", a_full, e_full);
    chk("proc2mem_command", 64'(a_cmd), 64'(e_cmd));
    chk("proc2mem_addr", a_paddr, e_paddr);
    chk("proc2mem_data", a_pdata, e_pdata);
  endtask

  task automatic drive(input BUS_COMMAND cmd, input logic [63:0] addr, input logic [63:0] data,
                       input logic [3:0] resp, input logic [3:0] mtag, input logic [63:0] mdata);
    c_cmd = cmd; c_addr = addr; c_data = data; c_resp = resp; c_mtag = mtag; c_mdata = mdata;
    bus.lsq2Dcache_command = cmd;  bus.lsq2Dcache_addr = addr; bus.lsq2Dcache_data = data;
    bus.mem2proc_response  = resp; bus.mem2proc_tag = mtag;    bus.mem2proc_data = mdata;
  endtask

  task automatic step(input BUS_COMMAND cmd, input logic [63:0] addr, input logic [63:0] data,
                      input logic [3:0] resp, input logic [3:0] mtag, input logic [63:0] mdata);
    @(negedge clock);
    drive(cmd, addr, data, resp, mtag, mdata);
    #1;
    model_outputs();
    sample_and_compare();
    @(posedge clock);
    model_commit();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    #1;
    q.delete();
    for (int i = 0; i < 32; i++) mv[i] = 0;
    model_outputs();
    sample_and_compare();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] ra, rd;
    logic [3:0]  rr, rt;
    int r;
    BUS_COMMAND rc;

    drive(BUS_NONE, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    do_reset();
    chk("reset_cmd", 64'(a_cmd), 64'(BUS_NONE));
    chk("reset_full", a_full, 0);

    // Miss then hit
    step(BUS_LOAD, 64'h100, 0, 4'd3, 4'd0, 0);
    chk("miss_cmd", 64'(a_cmd), 64'(BUS_LOAD));
    chk("miss_addr", a_paddr, 64'h100);
    chk("miss_resp", a_resp, 3);
    chk("miss_hit", a_hit, 0);
    step(BUS_NONE, 0, 0, 4'd0, 4'd3, 64'hDEAD);
    chk("fill_tag", a_tag, 3);
    chk("fill_data", a_fdata, 64'hDEAD);
    step(BUS_LOAD, 64'h104, 0, 4'd0, 4'd0, 0);
    chk("hit_flag", a_hit, 1);
    chk("hit_data", a_ldata, 64'hDEAD);
    chk("hit_cmd", 64'(a_cmd), 64'(BUS_NONE));

    // Memory busy
    step(BUS_LOAD, 64'h200, 0, 4'd0, 4'd0, 0);
    chk("busy_resp", a_resp, 0);
    step(BUS_NONE, 0, 0, 4'd0, 4'd0, 64'h1234);
    chk("busy_no_fill", a_tag, 0);

    // Store hit
    step(BUS_STORE, 64'h100, 64'h55, 4'd6, 4'd0, 0);
    chk("st_cmd", 64'(a_cmd), 64'(BUS_STORE));
    chk("st_data", a_pdata, 64'h55);
    chk("st_resp", a_resp, 6);
    step(BUS_LOAD, 64'h100, 0, 4'd0, 4'd0, 0);
    chk("st_hit_data", a_ldata, 64'h55);

    // MSHR full
    for (int i = 1; i <= 4; i++)
      step(BUS_LOAD, 64'h300 + 64'(i) * 64'h100, 0, 4'(i), 4'd0, 0);
    step(BUS_LOAD, 64'h800, 0, 4'd9, 4'd0, 0);
    chk("full_flag", a_full, 1);
    chk("full_cmd", 64'(a_cmd), 64'(BUS_NONE));
    chk("full_resp", a_resp, 0);
    step(BUS_LOAD, 64'h100, 0, 4'd0, 4'd0, 0);
    chk("full_hit", a_hit, 1);
    chk("full_hit_data", a_ldata, 64'h55);
    step(BUS_NONE, 0, 0, 4'd0, 4'd2, 64'hAB);
    chk("full_fill_same_cycle", a_full, 1);
    step(BUS_NONE, 0, 0, 4'd0, 4'd1, 64'hA1);
    chk("full_after_fill", a_full, 0);
    step(BUS_NONE, 0, 0, 4'd0, 4'd3, 64'hA3);
    step(BUS_NONE, 0, 0, 4'd0, 4'd4, 64'hA4);

    // Store under a pending miss
    step(BUS_LOAD, 64'h300, 0, 4'd5, 4'd0, 0);
    chk("pend_resp", a_resp, 5);
    step(BUS_STORE, 64'h300, 64'h77, 4'd8, 4'd0, 0);
    step(BUS_NONE, 0, 0, 4'd0, 4'd5, 64'h11);
    chk("pend_tag", a_tag, 5);
    chk("pend_data", a_fdata, 64'h11);
    step(BUS_LOAD, 64'h300, 0, 4'd0, 4'd0, 0);
    chk("pend_stale_miss", a_hit, 0);

    // Reset mid-operation
    step(BUS_LOAD, 64'h900, 0, 4'd7, 4'd0, 0);
    do_reset();
    step(BUS_NONE, 0, 0, 4'd0, 4'd7, 64'h99);
    chk("orphan_tag", a_tag, 0);
    step(BUS_LOAD, 64'h900, 0, 4'd0, 4'd0, 0);
    chk("orphan_no_line", a_hit, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      r = $urandom_range(0, 9);
      rc = (r < 3) ? BUS_NONE : (r < 7) ? BUS_LOAD : BUS_STORE;
      ra = (64'($urandom_range(0, 2)) << 8) | (64'($urandom_range(0, 7)) << 3)
           | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) ra[63:60] = 4'hF;
      rd = {$urandom, $urandom};
      rr = 4'd0;
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 64; k++) begin
          rr = 4'($urandom_range(1, 15));
          if (find_tag(rr) < 0) break;
        end
        if (find_tag(rr) >= 0) rr = 4'd0;
      end
      r = $urandom_range(0, 9);
      if (r < 4) rt = 4'd0;
      else if (r < 8 && q.size() > 0) rt = q[$urandom_range(0, q.size() - 1)].mt;
      else rt = 4'($urandom_range(1, 15));
      step(rc, ra, rd, rr, rt, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
